// File: rtl/butterfly_collector_pkg.sv
// Shared types and helpers for the butterfly serial-port collector.
// Holds the FSM encoding, default widths and the frame-length legality check.
package butterfly_collector_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DRAIN   = 2'd2
  } coll_state_e;

  localparam int DEF_DATA_WIDTH     = 16;
  localparam int DEF_BE_PARALLELISM = 32;
  localparam int DEF_PACK           = 4;

  // One packed output word: PACK samples for every lane.
  localparam int WORD_W = DEF_PACK * DEF_DATA_WIDTH * DEF_BE_PARALLELISM;

  // A frame must hold a whole number of packed words; pack is a power of two.
  function automatic logic len_legal(input logic [31:0] len, input int unsigned pack);
    return (len != '0) && ((len & (pack - 1)) == '0);
  endfunction

endpackage

// File: rtl/bfly_collect_fifo.sv
// Small synchronous FIFO for packed words (data plus last flag).
// full/empty/count are registered so they can feed ready logic without long paths.
module bfly_collect_fifo
  import butterfly_collector_pkg::*;
#(
  parameter int WIDTH = WORD_W + 1,
  parameter int DEPTH = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push,
  input  logic [WIDTH-1:0]               wdata,
  input  logic                           pop,
  output logic [WIDTH-1:0]               rdata,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             do_push, do_pop;

  assign do_push = push && !full_q;
  assign do_pop  = pop && !empty_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d = (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + AW'(1);
    end
    if (do_push && !do_pop) begin
      cnt_d = cnt_q + CW'(1);
    end else if (!do_push && do_pop) begin
      cnt_d = cnt_q - CW'(1);
    end
    full_d  = (cnt_d == CW'(DEPTH));
    empty_d = (cnt_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign full  = full_q;
  assign empty = empty_q;
  assign count = cnt_q;

endmodule

// File: rtl/butterfly_serial_collector.sv
// Receive endpoint for butterfly serial port A: packs PACK beats per lane into
// one wide word, frames them by a programmed length and streams them out.
module butterfly_serial_collector
  import butterfly_collector_pkg::*;
#(
  parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter int BE_PARALLELISM  = DEF_BE_PARALLELISM,
  parameter int OUTPUT_AXI_CHNL = 8,
  parameter int PACK            = DEF_PACK,
  parameter int FIFO_DEPTH      = 2,
  parameter int LEN_WIDTH       = 16
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      start,
  input  logic [LEN_WIDTH-1:0]                      length,
  input  logic [OUTPUT_AXI_CHNL-1:0]                up_vld,
  input  logic [DATA_WIDTH*BE_PARALLELISM-1:0]      up_dat,
  output logic                                      up_rdy,
  output logic                                      dn_vld,
  output logic [PACK*DATA_WIDTH*BE_PARALLELISM-1:0] dn_dat,
  output logic                                      dn_last,
  input  logic                                      dn_rdy,
  output logic                                      busy,
  output logic                                      done,
  output logic                                      err_len,
  output logic                                      err_vld
);

  localparam int WORD_BITS = PACK * DATA_WIDTH * BE_PARALLELISM;
  localparam int PCW       = (PACK > 1) ? $clog2(PACK) : 1;
  localparam int CW        = $clog2(FIFO_DEPTH + 1);

  coll_state_e state_q, state_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic [LEN_WIDTH-1:0] sample_cnt_q, sample_cnt_d;
  logic [PCW-1:0]       pack_cnt_q, pack_cnt_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 err_len_q, err_len_d;
  logic                 err_vld_q, err_vld_d;

  logic [BE_PARALLELISM-1:0][PACK-1:0][DATA_WIDTH-1:0] pack_q, pack_d, word_in;
  logic [BE_PARALLELISM-1:0][DATA_WIDTH-1:0]           lane_dat;

  logic            vld_all, vld_partial, beat, final_beat, pack_full;
  logic            fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CW-1:0]   fifo_cnt;
  logic [WORD_BITS:0] fifo_rdata;

  assign lane_dat    = up_dat;
  assign vld_all     = &up_vld;
  assign vld_partial = (|up_vld) && !vld_all;
  assign up_rdy      = (state_q == ST_COLLECT) && !fifo_full;
  assign beat        = vld_all && up_rdy;
  assign final_beat  = (sample_cnt_q == len_q - LEN_WIDTH'(1));
  assign pack_full   = (pack_cnt_q == PCW'(PACK - 1));
  assign fifo_push   = beat && pack_full;
  assign fifo_pop    = dn_vld && dn_rdy;

  // Current beat merged into its slot, so the PACK-th beat pushes a complete
  // word in the same cycle instead of waiting for the pack register to update.
  always_comb begin
    word_in = pack_q;
    for (int g = 0; g < BE_PARALLELISM; g++) begin
      word_in[g][pack_cnt_q] = lane_dat[g];
    end
  end

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    sample_cnt_d = sample_cnt_q;
    pack_cnt_d   = pack_cnt_q;
    pack_d       = pack_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    err_len_d    = err_len_q;
    err_vld_d    = err_vld_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (len_legal(32'(length), PACK)) begin
            len_d        = length;
            sample_cnt_d = '0;
            pack_cnt_d   = '0;
            busy_d       = 1'b1;
            state_d      = ST_COLLECT;
          end else begin
            err_len_d = 1'b1;
          end
        end
      end
      ST_COLLECT: begin
        if (vld_partial) err_vld_d = 1'b1;
        if (beat) begin
          pack_d       = word_in;
          pack_cnt_d   = pack_full ? '0 : pack_cnt_q + PCW'(1);
          sample_cnt_d = sample_cnt_q + LEN_WIDTH'(1);
          if (final_beat) begin
            sample_cnt_d = '0;
            state_d      = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        // Nothing is pushed here, so the FIFO draining to zero ends the frame.
        if (fifo_empty || (fifo_pop && fifo_cnt == CW'(1))) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      len_q        <= '0;
      sample_cnt_q <= '0;
      pack_cnt_q   <= '0;
      pack_q       <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_len_q    <= 1'b0;
      err_vld_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      sample_cnt_q <= sample_cnt_d;
      pack_cnt_q   <= pack_cnt_d;
      pack_q       <= pack_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_len_q    <= err_len_d;
      err_vld_q    <= err_vld_d;
    end
  end

  bfly_collect_fifo #(
    .WIDTH (WORD_BITS + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .wdata ({final_beat, word_in}),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

  assign dn_vld  = !fifo_empty;
  assign dn_dat  = fifo_rdata[WORD_BITS-1:0];
  assign dn_last = fifo_rdata[WORD_BITS];
  assign busy    = busy_q;
  assign done    = done_q;
  assign err_len = err_len_q;
  assign err_vld = err_vld_q;

endmodule

// File: tb/tb_butterfly_serial_collector.sv
// Directed bench for butterfly_serial_collector: frames, backpressure,
// partial valid, illegal lengths, mid-frame reset and start-while-busy.
module tb_butterfly_serial_collector;

  localparam int DW = 16, BE = 32, CH = 8, PK = 4, FD = 2, LW = 16;
  localparam int LANE_BITS = DW * BE;
  localparam int WORD_W    = PK * DW * BE;

  logic clk = 1'b0;
  logic rst, start, dn_rdy;
  logic [LW-1:0] length;
  logic [CH-1:0] up_vld;
  logic [LANE_BITS-1:0] up_dat;
  logic up_rdy, dn_vld, dn_last, busy, done, err_len, err_vld;
  logic [WORD_W-1:0] dn_dat;

  int checks = 0;
  int errors = 0;

  logic [WORD_W-1:0] words[$];
  logic              lasts[$];
  int done_cnt, first_vld_cyc, pack_beat_cyc, last_pop_cyc, done_cyc;
  int stall_err, rdy_err, max_lvl, timed_out;
  logic busy_at_done, busy_before_done;

  always #5 clk = ~clk;

  butterfly_serial_collector #(
    .DATA_WIDTH(DW), .BE_PARALLELISM(BE), .OUTPUT_AXI_CHNL(CH),
    .PACK(PK), .FIFO_DEPTH(FD), .LEN_WIDTH(LW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .length(length),
    .up_vld(up_vld), .up_dat(up_dat), .up_rdy(up_rdy),
    .dn_vld(dn_vld), .dn_dat(dn_dat), .dn_last(dn_last), .dn_rdy(dn_rdy),
    .busy(busy), .done(done), .err_len(err_len), .err_vld(err_vld)
  );

  // Lane g, sample j carries (g*256 + j) truncated to 16 bits.
  function automatic logic [LANE_BITS-1:0] beat_dat(input int j);
    logic [LANE_BITS-1:0] r;
    r = '0;
    for (int g = 0; g < BE; g++) r[g*DW +: DW] = 16'(g * 256 + j);
    return r;
  endfunction

  function automatic logic [WORD_W-1:0] exp_word(input int w);
    logic [WORD_W-1:0] r;
    r = '0;
    for (int g = 0; g < BE; g++)
      for (int k = 0; k < PK; k++)
        r[(g*PK + k)*DW +: DW] = 16'(g * 256 + w * PK + k);
    return r;
  endfunction

  // Cycle-by-cycle source/sink; cycle 0 is the first cycle in COLLECT.
  task automatic run_frame(input int len, input int hold0, input bit toggle,
                           input int partial_at, input int abort_at, input int bstart_at);
    int j, cyc, lvl, push, pop, budget;
    bit ppend, prev_stall, prev_last, busy_prev;
    logic [WORD_W-1:0] prev_dat;
    words.delete(); lasts.delete();
    done_cnt = 0; first_vld_cyc = -1; pack_beat_cyc = -1; last_pop_cyc = -1; done_cyc = -1;
    stall_err = 0; rdy_err = 0; max_lvl = 0; timed_out = 0;
    busy_at_done = 1'b1; busy_before_done = 1'b0;
    prev_stall = 0; prev_last = 0; prev_dat = '0; busy_prev = 0;
    j = 0; cyc = 0; lvl = 0; ppend = (partial_at >= 0);
    budget = len * 4 + hold0 + 100;
    dn_rdy = (hold0 == 0);
    length = LW'(len); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    forever begin
      if (abort_at >= 0 && j == abort_at) break;
      start = (cyc == bstart_at);
      if (cyc == bstart_at) length = LW'(4);
      if (j < len) begin
        if (ppend && j == partial_at) begin
          up_vld = 8'h0F; up_dat = {BE{16'hDEAD}};
        end else begin
          up_vld = '1; up_dat = beat_dat(j);
        end
      end else begin
        up_vld = '0; up_dat = '0;
      end
      if (cyc >= hold0) dn_rdy = toggle ? ~dn_rdy : 1'b1;
      @(negedge clk);
      if (j < len && up_rdy !== (lvl < 2)) rdy_err++;
      push = 0;
      if (up_vld == '1 && up_rdy === 1'b1) begin
        j++;
        if (j % PK == 0) push = 1;
        if (j == PK) pack_beat_cyc = cyc;
      end
      if (up_vld == 8'h0F) ppend = 0;
      if (dn_vld === 1'b1 && first_vld_cyc < 0) first_vld_cyc = cyc;
      if (prev_stall && (dn_dat !== prev_dat || dn_last !== prev_last)) stall_err++;
      prev_stall = dn_vld && !dn_rdy; prev_dat = dn_dat; prev_last = dn_last;
      pop = (dn_vld === 1'b1 && dn_rdy) ? 1 : 0;
      if (pop != 0) begin
        words.push_back(dn_dat); lasts.push_back(dn_last); last_pop_cyc = cyc;
      end
      if (done === 1'b1) begin
        done_cnt++; done_cyc = cyc; busy_at_done = busy; busy_before_done = busy_prev;
      end
      busy_prev = busy;
      lvl = lvl + push - pop;
      if (lvl > max_lvl) max_lvl = lvl;
      if (done_cyc >= 0 && cyc >= done_cyc + 5) break;
      if (cyc > budget) begin timed_out = 1; break; end
      @(posedge clk); #1;
      cyc++;
    end
    up_vld = '0; start = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; length = '0; up_vld = '0; up_dat = '0; dn_rdy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({up_rdy, dn_vld, dn_last, busy, done, err_len, err_vld} !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %b expected 0000000",
               {up_rdy, dn_vld, dn_last, busy, done, err_len, err_vld});
    end
    checks++;
    if (dn_dat !== '0) begin
      errors++; $display("FAIL reset_dat got %h expected 0", dn_dat[63:0]);
    end
    rst = 1'b0;
  endtask

  task automatic test_frame;
    int bad;
    run_frame(256, 0, 0, -1, -1, -1);
    checks++;
    if (words.size() !== 64) begin errors++; $display("FAIL frame_count got %0d expected 64", words.size()); end
    bad = 0;
    foreach (words[w]) if (words[w] !== exp_word(w) || lasts[w] !== (w == 63)) bad++;
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL frame_words got %0d bad expected 0", bad); end
    checks++;
    if (first_vld_cyc !== pack_beat_cyc + 1) begin
      errors++; $display("FAIL frame_latency got %0d expected %0d", first_vld_cyc, pack_beat_cyc + 1);
    end
    checks++;
    if (done_cnt !== 1 || timed_out !== 0) begin
      errors++; $display("FAIL frame_done got %0d pulses timeout %0d expected 1", done_cnt, timed_out);
    end
    checks++;
    if (done_cyc !== last_pop_cyc + 1) begin
      errors++; $display("FAIL frame_done_time got %0d expected %0d", done_cyc, last_pop_cyc + 1);
    end
    checks++;
    if (done_cyc !== 257) begin errors++; $display("FAIL frame_throughput got %0d expected 257", done_cyc); end
    checks++;
    if ({busy_before_done, busy_at_done} !== 2'b10) begin
      errors++; $display("FAIL frame_busy got %b expected 10", {busy_before_done, busy_at_done});
    end
  endtask

  task automatic test_backpressure;
    int bad;
    run_frame(16, 20, 1, -1, -1, -1);
    checks++;
    if (words.size() !== 4) begin errors++; $display("FAIL bp_count got %0d expected 4", words.size()); end
    bad = 0;
    foreach (words[w]) if (words[w] !== exp_word(w) || lasts[w] !== (w == 3)) bad++;
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL bp_words got %0d bad expected 0", bad); end
    checks++;
    if (stall_err !== 0) begin errors++; $display("FAIL bp_stable got %0d changes expected 0", stall_err); end
    checks++;
    if (rdy_err !== 0) begin errors++; $display("FAIL bp_up_rdy got %0d wrong cycles expected 0", rdy_err); end
    checks++;
    if (max_lvl !== 2) begin errors++; $display("FAIL bp_fill got %0d expected 2", max_lvl); end
    checks++;
    if (done_cnt !== 1) begin errors++; $display("FAIL bp_done got %0d expected 1", done_cnt); end
  endtask

  task automatic test_partial_vld;
    int bad;
    run_frame(256, 0, 0, 100, -1, -1);
    checks++;
    if (err_vld !== 1'b1) begin errors++; $display("FAIL pv_err_vld got %b expected 1", err_vld); end
    checks++;
    if (words.size() !== 64) begin errors++; $display("FAIL pv_count got %0d expected 64", words.size()); end
    bad = 0;
    foreach (words[w]) if (words[w] !== exp_word(w) || lasts[w] !== (w == 63)) bad++;
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL pv_words got %0d bad expected 0", bad); end
    checks++;
    if (done_cnt !== 1 || done_cyc !== 258) begin
      errors++; $display("FAIL pv_done got %0d pulses at %0d expected 1 at 258", done_cnt, done_cyc);
    end
  endtask

  task automatic test_illegal_len;
    int seen;
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    length = LW'(6); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if ({err_len, up_rdy, busy} !== 3'b100) begin
      errors++; $display("FAIL len6 got %b expected 100", {err_len, up_rdy, busy});
    end
    up_vld = '1; up_dat = beat_dat(0); dn_rdy = 1'b1; seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (dn_vld !== 1'b0 || up_rdy !== 1'b0 || err_len !== 1'b1) seen++;
      @(posedge clk); #1;
    end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL len6_idle got %0d bad cycles expected 0", seen); end
    up_vld = '0;
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    length = '0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if ({err_len, up_rdy, busy, dn_vld} !== 4'b1000) begin
      errors++; $display("FAIL len0 got %b expected 1000", {err_len, up_rdy, busy, dn_vld});
    end
  endtask

  task automatic test_reset_mid;
    int bad;
    run_frame(256, 0, 0, -1, 10, -1);
    rst = 1'b1; up_vld = '0;
    @(posedge clk); #1;
    checks++;
    if ({up_rdy, dn_vld, dn_last, busy, done, err_len, err_vld} !== 7'b0 || dn_dat !== '0) begin
      errors++;
      $display("FAIL midrst got %b dat %h expected 0",
               {up_rdy, dn_vld, dn_last, busy, done, err_len, err_vld}, dn_dat[63:0]);
    end
    rst = 1'b0;
    run_frame(8, 0, 0, -1, -1, -1);
    checks++;
    if (words.size() !== 2) begin errors++; $display("FAIL midrst_count got %0d expected 2", words.size()); end
    bad = 0;
    foreach (words[w]) if (words[w] !== exp_word(w) || lasts[w] !== (w == 1)) bad++;
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL midrst_words got %0d bad expected 0", bad); end
    checks++;
    if (done_cnt !== 1) begin errors++; $display("FAIL midrst_done got %0d expected 1", done_cnt); end
  endtask

  task automatic test_start_busy;
    int bad;
    run_frame(256, 0, 0, -1, -1, 50);
    checks++;
    if (words.size() !== 64) begin errors++; $display("FAIL sb_count got %0d expected 64", words.size()); end
    bad = 0;
    foreach (words[w]) if (words[w] !== exp_word(w) || lasts[w] !== (w == 63)) bad++;
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL sb_words got %0d bad expected 0", bad); end
    checks++;
    if (done_cnt !== 1 || done_cyc !== 257) begin
      errors++; $display("FAIL sb_done got %0d pulses at %0d expected 1 at 257", done_cnt, done_cyc);
    end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_backpressure();
    test_partial_vld();
    test_illegal_len();
    test_reset_mid();
    test_start_busy();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/butterfly_serial_collector.md
Name: butterfly_serial_collector

Overview:
- Receive-side endpoint for the butterfly processor's serial output port A.
- Accepts one fp16 sample per BE lane per beat, packs PACK consecutive samples per lane into one wide word, and forwards words over a valid/ready stream.
- Counts a programmed frame length and flags the last word. Reports frame completion and protocol errors.
- Sits between butterfly_processor and the write-back DMA/buffer.

Parameters:
DATA_WIDTH, 16, sample width (fp16)
BE_PARALLELISM, 32, lanes per beat
OUTPUT_AXI_CHNL, 8, width of per-channel valid vector
PACK, 4, samples per lane per output word (power of 2)
FIFO_DEPTH, 2, packed-word buffer entries
LEN_WIDTH, 16, frame length counter width

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
start  in  1  one-cycle pulse, begins a frame
length  in  LEN_WIDTH  samples per lane in the frame; sampled on start
up_vld  in  OUTPUT_AXI_CHNL  per-channel valid from dn_serial_vld_A
up_dat  in  DATA_WIDTH*BE_PARALLELISM  lane g at [g*DATA_WIDTH +: DATA_WIDTH]
up_rdy  out  1  drives dn_serial_rdy_A
dn_vld  out  1  packed word valid
dn_dat  out  PACK*DATA_WIDTH*BE_PARALLELISM  lane g, beat k at [(g*PACK+k)*DATA_WIDTH +: DATA_WIDTH]
dn_last  out  1  final word of the frame, qualified by dn_vld
dn_rdy  in  1  downstream ready
busy  out  1  high from start acceptance until done
done  out  1  one-cycle pulse at frame end
err_len  out  1  sticky: start was issued with an illegal length
err_vld  out  1  sticky: partial up_vld was seen (nonzero, not all ones)

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: all outputs are 0, FSM is IDLE, counters are 0, FIFO is empty. A reset mid-frame discards the partial pack and buffered words; no done pulse is issued.
- FSM states: IDLE, COLLECT, DRAIN.
- IDLE:
  - start with length != 0 and length % PACK == 0 latches length and goes to COLLECT; busy = 1 next cycle.
  - start with an illegal length sets err_len and stays in IDLE.
- COLLECT:
  - Beat accepted when &up_vld && up_rdy.
  - up_rdy = (state == COLLECT) && !fifo_full. fifo_full is registered.
  - Accepted samples are written into the pack register at slot pack_cnt. pack_cnt wraps modulo PACK.
  - On the PACK-th beat, the assembled word is pushed to the FIFO together with last = (sample_cnt == length-1).
  - When the final sample is accepted, go to DRAIN; up_rdy drops the next cycle.
- DRAIN: when the FIFO is empty and no handshake is pending, pulse done for 1 cycle, clear busy, go to IDLE.
- start while busy is ignored; the latched length is unchanged.
- Partial up_vld (nonzero, not all ones): sets err_vld, the beat is not accepted, counters do not advance.
- up_vld is ignored outside COLLECT.
- Output stream:
  - dn_vld = FIFO not empty.
  - dn_dat and dn_last come from the FIFO head (registered).
  - A word pops on dn_vld && dn_rdy.
  - dn_dat and dn_last hold stable while dn_vld && !dn_rdy.
- Latency: dn_vld rises 1 cycle after the PACK-th beat is accepted (empty FIFO case).
- FIFO full: up_rdy is low, so no push occurs. A pop in that cycle frees space, and up_rdy rises the next cycle. A push and pop in the same cycle on a non-full FIFO keep the count unchanged.
- Throughput: 1 sample per lane per cycle, sustained when dn_rdy is held at 1 (one word every PACK cycles).
- Counters:
  - sample_cnt is LEN_WIDTH bits, 0..length-1.
  - pack_cnt is $clog2(PACK) bits.
  - No overflow is possible because length is bounded by LEN_WIDTH.
- Samples are passed bit-exact; there is no arithmetic on data.

Decomposition:
- Package butterfly_collector_pkg holds:
  - the FSM state enum (IDLE/COLLECT/DRAIN);
  - the word-width localparam (PACK*DATA_WIDTH*BE_PARALLELISM);
  - a helper function for the legal-length check.
- Sub-module bfly_collect_fifo: a synchronous FIFO of width word+1 (last bit), depth FIFO_DEPTH, with registered full and empty. The top level contains the FSM, counters and pack register.

Test Plan:
- Frame, no backpressure: length=256, lane g beat j = 16'h(g*256+j)[15:0], dn_rdy=1 → 64 words. Word w lane g holds beats 4w..4w+3 in ascending slot order. dn_last only on word 63. done pulses 1 cycle after the last pop. busy falls with done.
- Backpressure: length=16, dn_rdy toggles 1/0 per cycle → 4 words, none lost or duplicated, dn_dat stable while stalled, up_rdy low whenever 2 words are buffered.
- Partial valid: up_vld=8'h0F for one cycle mid-frame → err_vld=1 sticky, sample_cnt unchanged, frame still completes with the correct 64 words when length=256.
- Illegal length: start with length=6, then with length=0 → err_len=1, FSM stays IDLE, up_rdy=0, no dn_vld.
- Reset mid-frame: rst high after 10 beats of a length=256 frame → next cycle all outputs 0. A new start with length=8 yields exactly 2 words and one done.
- Start while busy: second start with length=4 during a length=256 frame → ignored. Exactly 64 words and a single done.
